pingpong_buf_ctrl: RTL and testbench

- Double-buffer (ping-pong) controller around one internal `ram` instance.
- Sits between the per-chirp sample stream (ADC/FIR output) and the FFT/readout path.
- The writer fills one bank of DEPTH samples while the reader drains the other, with valid/ready handshakes on both sides.
- Bank sequencing guarantees the RAM never sees a same-address read/write collision.

---
 rtl/pingpong_buf_ctrl_pkg.sv | 18 +
 rtl/pingpong_buf_ctrl_if.sv | 24 ++
 rtl/pingpong_buf_ctrl_ram.sv | 26 ++
 rtl/pingpong_buf_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pingpong_buf_ctrl.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/pingpong_buf_ctrl_pkg.sv
// Shared definitions for the ping-pong buffer controller: bank state encoding,
// skid depth and RAM address packing.
package pingpong_buf_ctrl_pkg;

  typedef enum logic {
    BANK_EMPTY = 1'b0,
    BANK_FULL  = 1'b1
  } bank_state_e;

  localparam int SKID_DEPTH = 2;

  // Bank select sits directly above the offset bits.
  function automatic int unsigned ram_addr(input logic bank, input int unsigned offset,
                                           input int abits);
    return ({31'd0, bank} << abits) | offset;
  endfunction

endpackage

// File: rtl/pingpong_buf_ctrl_if.sv
// Sample-in / sample-out handshake bundle of the ping-pong buffer; master is the
// stream source + readout sink, slave is the buffer.
interface pingpong_buf_ctrl_if #(
  parameter int WIDTH = 64
);
  logic             wr_valid;
  logic [WIDTH-1:0] wr_data;
  logic             wr_ready;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;
  logic             rd_last;
  logic             rd_ready;
  logic             overflow;

  modport master (
    output wr_valid, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_data, rd_last, overflow
  );

  modport slave (
    input  wr_valid, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_data, rd_last, overflow
  );
endinterface

// File: rtl/pingpong_buf_ctrl_ram.sv
// Simple dual-port RAM, 1-cycle registered read; a write to the address being
// read in the same cycle is dropped (read has priority).
module ram #(
  parameter  int WIDTH = 64,
  parameter  int SIZE  = 2048,
  localparam int AW    = $clog2(SIZE)
) (
  input  logic             rdclk,
  input  logic             rden,
  input  logic [AW-1:0]    rdaddr,
  output logic [WIDTH-1:0] rddata,
  input  logic             wrclk,
  input  logic             wren,
  input  logic [AW-1:0]    wraddr,
  input  logic [WIDTH-1:0] wrdata
);
  logic [WIDTH-1:0] mem [SIZE];

  always_ff @(posedge rdclk) begin
    if (rden) rddata <= mem[rdaddr];
  end

  always_ff @(posedge wrclk) begin
    if (wren && !(rden && (rdaddr == wraddr))) mem[wraddr] <= wrdata;
  end
endmodule

// File: rtl/pingpong_buf_ctrl.sv
// Ping-pong frame buffer between the chirp sample stream and FFT readout; a frame is visible
// 2 cycles after its last write. rd_ready low parks reads in a 2-deep skid; two full banks drop wr_ready.
module pingpong_buf_ctrl #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 1024
) (
  input logic                clk,
  input logic                rst_n,
  input logic                clr,
  pingpong_buf_ctrl_if.slave bus
);
  import pingpong_buf_ctrl_pkg::*;

  localparam int ABITS = $clog2(DEPTH);
  localparam int AW    = ABITS + 1;
  localparam logic [ABITS-1:0] LAST_OFS = ABITS'(DEPTH - 1);

  logic [1:0]       bank_full;
  logic             wr_bank, rd_bank;
  logic [ABITS-1:0] wr_cnt, rd_cnt;
  logic             inflight, inflight_last;
  logic [1:0]       skid_cnt;
  logic [WIDTH-1:0] skid_dat  [SKID_DEPTH];
  logic             skid_last [SKID_DEPTH];
  logic             ovf_q;
  logic [WIDTH-1:0] ram_rddata;
  logic [AW-1:0]    rd_addr, wr_addr;
  logic [1:0]       occ;
  logic             wr_fire, wr_end, rd_issue, rd_end;
  logic             bypass_pop, skid_pop, skid_push;

  assign bus.wr_ready = (bank_full[wr_bank] == BANK_EMPTY) && !clr;
  assign wr_fire      = bus.wr_valid && bus.wr_ready;
  assign wr_end       = wr_fire && (wr_cnt == LAST_OFS);

  // Outstanding RAM read counts against skid space so a stalled sink never loses data.
  assign occ      = skid_cnt + {1'b0, inflight};
  assign rd_issue = (bank_full[rd_bank] == BANK_FULL) && (occ < 2'(SKID_DEPTH)) && !clr;
  assign rd_end   = rd_issue && (rd_cnt == LAST_OFS);

  assign wr_addr = AW'(ram_addr(wr_bank, 32'(wr_cnt), ABITS));
  assign rd_addr = AW'(ram_addr(rd_bank, 32'(rd_cnt), ABITS));

  ram #(
    .WIDTH (WIDTH),
    .SIZE  (2 * DEPTH)
  ) u_ram (
    .rdclk  (clk),
    .rden   (rd_issue),
    .rdaddr (rd_addr),
    .rddata (ram_rddata),
    .wrclk  (clk),
    .wren   (wr_fire),
    .wraddr (wr_addr),
    .wrdata (bus.wr_data)
  );

  // Offsets wrap naturally since DEPTH is a power of two; write-set and read-clear
  // always hit different banks, so both updates land.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_full <= 2'b00;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
    end else if (clr) begin
      bank_full <= 2'b00;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
    end else begin
      if (wr_fire) wr_cnt <= wr_cnt + 1'b1;
      if (wr_end) begin
        bank_full[wr_bank] <= BANK_FULL;
        wr_bank            <= !wr_bank;
      end
      if (rd_issue) rd_cnt <= rd_cnt + 1'b1;
      if (rd_end) begin
        bank_full[rd_bank] <= BANK_EMPTY;
        rd_bank            <= !rd_bank;
      end
    end
  end

  // A returning word goes straight out when the skid is empty and the sink is ready.
  assign bypass_pop = inflight && (skid_cnt == 2'd0) && bus.rd_ready;
  assign skid_pop   = (skid_cnt != 2'd0) && bus.rd_ready;
  assign skid_push  = inflight && !bypass_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      skid_cnt      <= 2'd0;
      for (int i = 0; i < SKID_DEPTH; i++) begin
        skid_dat[i]  <= '0;
        skid_last[i] <= 1'b0;
      end
    end else if (clr) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      skid_cnt      <= 2'd0;
    end else begin
      inflight      <= rd_issue;
      inflight_last <= rd_end;
      case ({skid_push, skid_pop})
        2'b10: begin
          if (skid_cnt == 2'd0) begin
            skid_dat[0]  <= ram_rddata;
            skid_last[0] <= inflight_last;
          end else begin
            skid_dat[1]  <= ram_rddata;
            skid_last[1] <= inflight_last;
          end
          skid_cnt <= skid_cnt + 2'd1;
        end
        2'b01: begin
          skid_dat[0]  <= skid_dat[1];
          skid_last[0] <= skid_last[1];
          skid_cnt     <= skid_cnt - 2'd1;
        end
        2'b11: begin
          if (skid_cnt == 2'd1) begin
            skid_dat[0]  <= ram_rddata;
            skid_last[0] <= inflight_last;
          end else begin
            skid_dat[0]  <= skid_dat[1];
            skid_last[0] <= skid_last[1];
            skid_dat[1]  <= ram_rddata;
            skid_last[1] <= inflight_last;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.rd_valid = 1'b0;
    bus.rd_data  = '0;
    bus.rd_last  = 1'b0;
    if (skid_cnt != 2'd0) begin
      bus.rd_valid = 1'b1;
      bus.rd_data  = skid_dat[0];
      bus.rd_last  = skid_last[0];
    end else if (inflight) begin
      bus.rd_valid = 1'b1;
      bus.rd_data  = ram_rddata;
      bus.rd_last  = inflight_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 ovf_q <= 1'b0;
    else if (clr)                               ovf_q <= 1'b0;
    else if (bus.wr_valid && !bus.wr_ready)     ovf_q <= 1'b1;
  end
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_pingpong_buf_ctrl.sv
// Directed vector bench for pingpong_buf_ctrl at WIDTH=16, DEPTH=4.
module tb_pingpong_buf_ctrl;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clr   = 1'b0;

  always #5 clk = ~clk;

  pingpong_buf_ctrl_if #(.WIDTH(WIDTH)) bus ();

  pingpong_buf_ctrl #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus)
  );

  typedef struct packed {
    logic        wv;
    logic [15:0] wd;
    logic        rr;
    logic        cl;
    logic        ewr;
    logic        erv;
    logic [15:0] erd;
    logic        erl;
    logic        eov;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   lasts = 0;

  task automatic check(input string nm, input int idx, input logic ewr, input logic erv,
                       input logic [15:0] erd, input logic erl, input logic eov);
    logic [19:0] got, want;
    got  = {bus.wr_ready, bus.rd_valid, bus.rd_data, bus.rd_last, bus.overflow};
    want = {ewr, erv, erd, erl, eov};
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s[%0d]: got wr_ready=%b rd_valid=%b rd_data=%h rd_last=%b overflow=%b, want wr_ready=%b rd_valid=%b rd_data=%h rd_last=%b overflow=%b",
               nm, idx, got[19], got[18], got[17:2], got[1], got[0],
               ewr, erv, erd, erl, eov);
    end
  endtask

  task automatic add(input int wv, input int wd, input int rr, input int cl,
                     input int ewr, input int erv, input int erd, input int erl, input int eov);
    vec_t v;
    v.wv  = wv[0];
    v.wd  = wd[15:0];
    v.rr  = rr[0];
    v.cl  = cl[0];
    v.ewr = ewr[0];
    v.erv = erv[0];
    v.erd = erd[15:0];
    v.erl = erl[0];
    v.eov = eov[0];
    tbl.push_back(v);
  endtask

  task automatic run_table(input string nm);
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      bus.wr_valid = tbl[i].wv;
      bus.wr_data  = tbl[i].wd;
      bus.rd_ready = tbl[i].rr;
      clr          = tbl[i].cl;
      #1;
      check(nm, i, tbl[i].ewr, tbl[i].erv, tbl[i].erd, tbl[i].erl, tbl[i].eov);
    end
    tbl.delete();
  endtask

  // Four writes, then the frame drains two cycles after the last one.
  task automatic build_single(input int base);
    for (int i = 0; i < 4; i++) add(1, base + i, 1, 0, 1, 0, 0, 0, 0);
    add(0, 0, 1, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 1, 0, 1, 1, base + i, (i == 3) ? 1 : 0, 0);
    add(0, 0, 1, 0, 1, 0, 0, 0, 0);
  endtask

  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.rd_ready = 1'b1;
    #3;
    check("reset", 0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    #9 rst_n = 1'b1;

    build_single(16'h10);
    run_table("single");

    // Three back-to-back frames.
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      bus.wr_valid = (k < 12);
      bus.wr_data  = 16'h0030 + 16'(k);
      bus.rd_ready = 1'b1;
      #1;
      if (k >= 5 && k <= 16)
        check("stream", k, 1'b1, 1'b1, 16'h0030 + 16'(k - 5), ((k - 5) % 4) == 3, 1'b0);
      else
        check("stream", k, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
      if (bus.rd_valid && bus.rd_last) lasts++;
    end
    n_vec++;
    if (lasts != 3) begin
      n_bad++;
      $display("FAIL stream_last_count: got %0d, want 3", lasts);
    end

    // Both banks fill with the sink stalled; the 9th sample is dropped.
    for (int i = 0; i < 4; i++) add(1, 16'h40 + i, 0, 0, 1, 0, 0, 0, 0);
    add(1, 16'h44, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 5; i < 8; i++) add(1, 16'h40 + i, 0, 0, 1, 1, 16'h40, 0, 0);
    add(1, 16'hAA, 0, 0, 0, 1, 16'h40, 0, 0);
    add(0, 0, 0, 0, 0, 1, 16'h40, 0, 1);
    add(0, 0, 1, 0, 0, 1, 16'h40, 0, 1);
    add(0, 0, 1, 0, 0, 1, 16'h41, 0, 1);
    add(0, 0, 1, 0, 0, 1, 16'h42, 0, 1);
    add(0, 0, 1, 0, 1, 1, 16'h43, 1, 1);
    for (int i = 4; i < 8; i++) add(0, 0, 1, 0, 1, 1, 16'h40 + i, (i == 7) ? 1 : 0, 1);
    add(0, 0, 1, 0, 1, 0, 0, 0, 1);
    add(0, 0, 1, 1, 0, 0, 0, 0, 1);
    add(0, 0, 1, 0, 1, 0, 0, 0, 0);
    run_table("full_stall");

    // Sink readiness 1,0,0,1 while draining one frame.
    for (int i = 0; i < 4; i++) add(1, 16'h50 + i, 1, 0, 1, 0, 0, 0, 0);
    add(0, 0, 1, 0, 1, 0, 0, 0, 0);
    add(0, 0, 1, 0, 1, 1, 16'h50, 0, 0);
    add(0, 0, 0, 0, 1, 1, 16'h51, 0, 0);
    add(0, 0, 0, 0, 1, 1, 16'h51, 0, 0);
    add(0, 0, 1, 0, 1, 1, 16'h51, 0, 0);
    add(0, 0, 1, 0, 1, 1, 16'h52, 0, 0);
    add(0, 0, 1, 0, 1, 1, 16'h53, 1, 0);
    add(0, 0, 1, 0, 1, 0, 0, 0, 0);
    run_table("backpressure");

    // Partial frame discarded by clr; a sample offered during clr is not an overflow.
    add(1, 16'h60, 1, 0, 1, 0, 0, 0, 0);
    add(1, 16'h61, 1, 0, 1, 0, 0, 0, 0);
    add(1, 16'h99, 1, 1, 0, 0, 0, 0, 0);
    build_single(16'h20);
    run_table("clr_mid");

    // Async reset in the middle of a drain.
    for (int i = 0; i < 4; i++) add(1, 16'h70 + i, 1, 0, 1, 0, 0, 0, 0);
    add(0, 0, 1, 0, 1, 0, 0, 0, 0);
    add(0, 0, 1, 0, 1, 1, 16'h70, 0, 0);
    add(0, 0, 1, 0, 1, 1, 16'h71, 0, 0);
    run_table("pre_rst");
    #2 rst_n = 1'b0;
    #1;
    check("async_rst", 0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    build_single(16'h10);
    run_table("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
